// File: rtl/fifo_read_drainer.sv
// ---------------------------------------------------------------------------
// fifo_read_drainer
//
// Read-side controller for a FIFO with one-cycle read latency. A start command
// programs a word count. The block pops that many words from the FIFO and
// hands them to a valid/ready sink. A 2-entry buffer absorbs the FIFO read
// latency, so the block moves one word per cycle while the sink stays ready,
// and no word is lost under back-pressure.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      one-cycle command pulse (ignored while busy_o)
//   len_i        words to transfer, sampled when start_i is accepted
//   empty_i      FIFO empty flag (current cycle)
//   read_en_o    FIFO pop request (combinational)
//   fifo_dout_i  FIFO read data, valid one cycle after read_en_o
//   m_valid_o    output word valid
//   m_data_o     output word
//   m_ready_i    sink ready; a word moves on m_valid_o & m_ready_i
//   busy_o       transfer in progress (RUN, FLUSH or DONE)
//   done_o       one-cycle pulse after the last word is accepted
//   rd_count_o   words delivered in the current or last transfer
// ---------------------------------------------------------------------------
module fifo_read_drainer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             empty_i,
    output logic             read_en_o,
    input  logic [WIDTH-1:0] fifo_dout_i,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] rd_count_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] rdCount_q, rdCount_d;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q;
    logic             head_q, tail_q;
    logic [WIDTH-1:0] dataBuf_q [2];

    logic             pop;
    logic             startAccept;
    logic             readEn;
    logic [2:0]       credit;

    // Handshake, read-issue credit and counter next-state values.
    // The credit counts buffer slots already promised: words held plus a word
    // still coming back from the FIFO, minus the word leaving this cycle. A
    // new read is only issued if that leaves room in the 2-entry buffer.
    always_comb begin
        startAccept = (state_q == IDLE) && start_i;
        pop         = (occ_q != 2'd0) && m_ready_i;
        credit      = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        readEn      = !rst_i && (state_q == RUN) && !empty_i &&
                      (remaining_q != '0) && (credit < 3'd2);
        occ_d       = occ_q + 2'(inflight_q) - 2'(pop);

        remaining_d = remaining_q;
        if (startAccept) begin
            remaining_d = len_i;
        end else if (readEn) begin
            remaining_d = remaining_q - CNT_W'(1);
        end

        // rd_count cannot really wrap since len_i fits in CNT_W bits, but it
        // is held at all-ones rather than rolling over just in case.
        rdCount_d = rdCount_q;
        if (startAccept) begin
            rdCount_d = '0;
        end else if (pop && (rdCount_q != '1)) begin
            rdCount_d = rdCount_q + CNT_W'(1);
        end
    end

    // Transfer sequencing. FLUSH waits until the final word has left the
    // buffer and no read is outstanding; this lands DONE one cycle after the
    // last handshake. A zero-length command goes straight to DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= (len_i != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (readEn && (remaining_q == CNT_W'(1))) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!inflight_q && (occ_d == 2'd0)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Two-entry circular output buffer plus counters. Data returned by the
    // FIFO lands at the tail one cycle after the read; a handshake advances
    // the head. Reset also drops a read still in flight, so its data is never
    // captured.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            remaining_q  <= '0;
            rdCount_q    <= '0;
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            dataBuf_q[0] <= '0;
            dataBuf_q[1] <= '0;
        end else begin
            remaining_q <= remaining_d;
            rdCount_q   <= rdCount_d;
            occ_q       <= occ_d;
            inflight_q  <= readEn;
            if (inflight_q) begin
                dataBuf_q[tail_q] <= fifo_dout_i;
                tail_q            <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
        end
    end

    assign read_en_o  = readEn;
    assign m_valid_o  = (occ_q != 2'd0);
    assign m_data_o   = dataBuf_q[head_q];
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign rd_count_o = rdCount_q;

endmodule

// File: tb/tb_fifo_read_drainer.sv
// ---------------------------------------------------------------------------
// tb_fifo_read_drainer
//
// Bench for fifo_read_drainer. The FIFO is modelled as a queue that pops when
// read_en_o was high and presents the popped word one cycle later. Directed
// scenarios check cycle-exact timing. A randomized scenario checks the
// delivered stream against the pushed words, plus the handshake rules.
// ---------------------------------------------------------------------------
module tb_fifo_read_drainer;

   localparam int WIDTH = 8;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_i;
   logic             start_i;
   logic [CNT_W-1:0] len_i;
   logic             empty_i;
   logic             read_en_o;
   logic [WIDTH-1:0] fifo_dout_i;
   logic             m_valid_o;
   logic [WIDTH-1:0] m_data_o;
   logic             m_ready_i;
   logic             busy_o;
   logic             done_o;
   logic [CNT_W-1:0] rd_count_o;

   int checks = 0;
   int errors = 0;
   int popCount = 0;

   logic [7:0] fifoQ[$];
   logic [7:0] gotQ[$];
   int         gotC[$];

   logic       reA[64];
   logic       mvA[64];
   logic       dnA[64];
   logic       bsA[64];
   logic [7:0] mdA[64];
   logic [7:0] rcA[64];

   fifo_read_drainer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .len_i      (len_i),
      .empty_i    (empty_i),
      .read_en_o  (read_en_o),
      .fifo_dout_i(fifo_dout_i),
      .m_valid_o  (m_valid_o),
      .m_data_o   (m_data_o),
      .m_ready_i  (m_ready_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .rd_count_o (rd_count_o)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Hard stop in case some wait is not bounded as intended
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got timeout expected finish");
      $fatal(1, "[TB] watchdog");
   end

   // Advance one cycle; the FIFO model pops on a sampled read_en
   task automatic tick();
      logic rd;
      #1;
      rd = read_en_o;
      @(posedge clk);
      #1;
      if (rd) begin
         popCount++;
         if (fifoQ.size() > 0) fifo_dout_i = fifoQ.pop_front();
         else fifo_dout_i = 'x;
      end
      empty_i = (fifoQ.size() == 0);
      @(negedge clk);
   endtask

   task automatic pushWord(input logic [7:0] w);
      fifoQ.push_back(w);
      empty_i = 1'b0;
   endtask

   task automatic recordCycle(input int c);
      #1;
      reA[c] = read_en_o;
      mvA[c] = m_valid_o;
      mdA[c] = m_data_o;
      dnA[c] = done_o;
      bsA[c] = busy_o;
      rcA[c] = rd_count_o;
      if (m_valid_o && m_ready_i) begin
         gotQ.push_back(m_data_o);
         gotC.push_back(c);
      end
   endtask

   task automatic doReset();
      rst_i = 1'b1;
      start_i = 1'b0;
      len_i = '0;
      m_ready_i = 1'b0;
      fifoQ.delete();
      gotQ.delete();
      gotC.delete();
      empty_i = 1'b1;
      fifo_dout_i = '0;
      tick();
      tick();
      rst_i = 1'b0;
      popCount = 0;
      for (int i = 0; i < 64; i++) begin
         reA[i] = 0; mvA[i] = 0; dnA[i] = 0; bsA[i] = 0; mdA[i] = 0; rcA[i] = 0;
      end
   endtask

   // Outputs while reset is held, even with a start request and data ready
   task automatic test_reset();
      rst_i = 1'b1;
      start_i = 1'b1;
      len_i = 8'd3;
      m_ready_i = 1'b1;
      pushWord(8'h55);
      tick();
      #1;
      checks++; if (read_en_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_read_en got %0b expected 0", read_en_o); end
      checks++; if (m_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid got %0b expected 0", m_valid_o); end
      checks++; if (m_data_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_m_data got %0h expected 0", m_data_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b expected 0", busy_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b expected 0", done_o); end
      checks++; if (rd_count_o !== 8'd0) begin errors++; $display("[TB] FAIL reset_rd_count got %0d expected 0", rd_count_o); end
      start_i = 1'b0;
      rst_i = 1'b0;
      tick();
      #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_start_ignored got busy %0b expected 0", busy_o); end
   endtask

   // len=4, sink always ready: reads 1..4, data 3..6, done at 7
   task automatic test_basic_drain();
      logic expRe;
      doReset();
      for (int i = 0; i < 4; i++) pushWord(8'h11 + 8'(i));
      m_ready_i = 1'b1;
      len_i = 8'd4;
      for (int c = 0; c < 12; c++) begin
         start_i = (c == 0);
         recordCycle(c);
         tick();
      end
      for (int c = 0; c < 12; c++) begin
         expRe = (c >= 1 && c <= 4);
         checks++; if (reA[c] !== expRe) begin errors++; $display("[TB] FAIL basic_read_en cycle %0d got %0b expected %0b", c, reA[c], expRe); end
         checks++; if (dnA[c] !== (c == 7)) begin errors++; $display("[TB] FAIL basic_done cycle %0d got %0b expected %0b", c, dnA[c], (c == 7)); end
      end
      for (int c = 3; c <= 6; c++) begin
         checks++; if (mvA[c] !== 1'b1 || mdA[c] !== 8'h11 + 8'(c - 3)) begin
            errors++; $display("[TB] FAIL basic_data cycle %0d got v%0b %0h expected v1 %0h", c, mvA[c], mdA[c], 8'h11 + 8'(c - 3));
         end
      end
      checks++; if (mvA[7] !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_after got %0b expected 0", mvA[7]); end
      checks++; if (rcA[7] !== 8'd4) begin errors++; $display("[TB] FAIL basic_rd_count got %0d expected 4", rcA[7]); end
      checks++; if (bsA[7] !== 1'b1 || bsA[8] !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy got %0b%0b expected 10", bsA[7], bsA[8]); end
   endtask

   // Sink stalls cycles 3..8: two reads, head word held, stream intact after
   task automatic test_back_pressure();
      logic expRe;
      doReset();
      for (int i = 0; i < 4; i++) pushWord(8'h11 + 8'(i));
      len_i = 8'd4;
      for (int c = 0; c < 16; c++) begin
         start_i = (c == 0);
         m_ready_i = !(c >= 3 && c <= 8);
         recordCycle(c);
         tick();
      end
      for (int c = 0; c < 16; c++) begin
         expRe = (c == 1 || c == 2 || c == 9 || c == 10);
         checks++; if (reA[c] !== expRe) begin errors++; $display("[TB] FAIL bp_read_en cycle %0d got %0b expected %0b", c, reA[c], expRe); end
         checks++; if (dnA[c] !== (c == 13)) begin errors++; $display("[TB] FAIL bp_done cycle %0d got %0b expected %0b", c, dnA[c], (c == 13)); end
      end
      for (int c = 3; c <= 8; c++) begin
         checks++; if (mvA[c] !== 1'b1 || mdA[c] !== 8'h11) begin
            errors++; $display("[TB] FAIL bp_hold cycle %0d got v%0b %0h expected v1 11", c, mvA[c], mdA[c]);
         end
      end
      checks++; if (gotQ.size() != 4) begin errors++; $display("[TB] FAIL bp_count got %0d expected 4", gotQ.size()); end
      for (int i = 0; i < gotQ.size() && i < 4; i++) begin
         checks++; if (gotQ[i] !== 8'h11 + 8'(i)) begin errors++; $display("[TB] FAIL bp_order word %0d got %0h expected %0h", i, gotQ[i], 8'h11 + 8'(i)); end
      end
   endtask

   // FIFO runs dry after 2 words; more words at cycle 8 resume the transfer
   task automatic test_empty_stall();
      logic expRe;
      int   lastHs;
      doReset();
      pushWord(8'hA0);
      pushWord(8'hA1);
      m_ready_i = 1'b1;
      len_i = 8'd4;
      for (int c = 0; c < 20; c++) begin
         start_i = (c == 0);
         if (c == 8) begin
            pushWord(8'hA2);
            pushWord(8'hA3);
         end
         recordCycle(c);
         tick();
      end
      for (int c = 0; c < 20; c++) begin
         expRe = (c == 1 || c == 2 || c == 8 || c == 9);
         checks++; if (reA[c] !== expRe) begin errors++; $display("[TB] FAIL stall_read_en cycle %0d got %0b expected %0b", c, reA[c], expRe); end
      end
      for (int c = 3; c <= 7; c++) begin
         checks++; if (bsA[c] !== 1'b1 || dnA[c] !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_wait cycle %0d got busy %0b done %0b expected busy 1 done 0", c, bsA[c], dnA[c]);
         end
      end
      checks++; if (gotQ.size() != 4) begin errors++; $display("[TB] FAIL stall_count got %0d expected 4", gotQ.size()); end
      for (int i = 0; i < gotQ.size() && i < 4; i++) begin
         checks++; if (gotQ[i] !== 8'hA0 + 8'(i)) begin errors++; $display("[TB] FAIL stall_order word %0d got %0h expected %0h", i, gotQ[i], 8'hA0 + 8'(i)); end
      end
      lastHs = (gotC.size() > 0) ? gotC[gotC.size() - 1] : 0;
      for (int c = 0; c < 20; c++) begin
         checks++; if (dnA[c] !== (c == lastHs + 1)) begin errors++; $display("[TB] FAIL stall_done cycle %0d got %0b expected %0b", c, dnA[c], (c == lastHs + 1)); end
      end
   endtask

   // len=0: done at cycle 1, no reads, start during DONE ignored
   task automatic test_zero_length();
      doReset();
      pushWord(8'h77);
      m_ready_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         start_i = (c == 0 || c == 1);
         len_i = (c == 0) ? 8'd0 : 8'd3;
         recordCycle(c);
         tick();
      end
      for (int c = 0; c < 6; c++) begin
         checks++; if (reA[c] !== 1'b0) begin errors++; $display("[TB] FAIL zero_read_en cycle %0d got %0b expected 0", c, reA[c]); end
         checks++; if (dnA[c] !== (c == 1)) begin errors++; $display("[TB] FAIL zero_done cycle %0d got %0b expected %0b", c, dnA[c], (c == 1)); end
         checks++; if (bsA[c] !== (c == 1)) begin errors++; $display("[TB] FAIL zero_busy cycle %0d got %0b expected %0b", c, bsA[c], (c == 1)); end
      end
      checks++; if (rcA[2] !== 8'd0) begin errors++; $display("[TB] FAIL zero_rd_count got %0d expected 0", rcA[2]); end
      checks++; if (popCount != 0) begin errors++; $display("[TB] FAIL zero_pops got %0d expected 0", popCount); end
   endtask

   // Reset during cycle 4 of an 8-word transfer
   task automatic test_reset_mid_transfer();
      logic expRe;
      doReset();
      for (int i = 0; i < 8; i++) pushWord(8'hC0 + 8'(i));
      m_ready_i = 1'b1;
      len_i = 8'd8;
      for (int c = 0; c < 12; c++) begin
         start_i = (c == 0);
         rst_i = (c == 4);
         recordCycle(c);
         tick();
      end
      rst_i = 1'b0;
      for (int c = 0; c < 12; c++) begin
         expRe = (c >= 1 && c <= 3);
         checks++; if (reA[c] !== expRe) begin errors++; $display("[TB] FAIL rstmid_read_en cycle %0d got %0b expected %0b", c, reA[c], expRe); end
         checks++; if (dnA[c] !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_done cycle %0d got %0b expected 0", c, dnA[c]); end
      end
      checks++; if (mvA[3] !== 1'b1 || mdA[3] !== 8'hC0) begin errors++; $display("[TB] FAIL rstmid_pre got v%0b %0h expected v1 c0", mvA[3], mdA[3]); end
      checks++; if (mvA[5] !== 1'b0 || mdA[5] !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_out got v%0b %0h expected v0 0", mvA[5], mdA[5]); end
      checks++; if (bsA[5] !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %0b expected 0", bsA[5]); end
      checks++; if (rcA[5] !== 8'd0) begin errors++; $display("[TB] FAIL rstmid_rd_count got %0d expected 0", rcA[5]); end
      for (int c = 5; c < 12; c++) begin
         checks++; if (mvA[c] !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_capture cycle %0d got %0b expected 0", c, mvA[c]); end
      end
      checks++; if (popCount != 3) begin errors++; $display("[TB] FAIL rstmid_pops got %0d expected 3", popCount); end
   endtask

   // A second start during a busy len=5 transfer has no effect
   task automatic test_ignored_start();
      int doneCount;
      int doneAt;
      doReset();
      for (int i = 0; i < 8; i++) pushWord(8'h30 + 8'(i));
      m_ready_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         start_i = (c == 0 || c == 3);
         len_i = (c == 0) ? 8'd5 : 8'd3;
         recordCycle(c);
         tick();
      end
      doneCount = 0;
      doneAt = 0;
      for (int c = 0; c < 20; c++) begin
         if (dnA[c]) begin doneCount++; doneAt = c; end
      end
      checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL ign_done_count got %0d expected 1", doneCount); end
      checks++; if (gotQ.size() != 5) begin errors++; $display("[TB] FAIL ign_words got %0d expected 5", gotQ.size()); end
      for (int i = 0; i < gotQ.size() && i < 5; i++) begin
         checks++; if (gotQ[i] !== 8'h30 + 8'(i)) begin errors++; $display("[TB] FAIL ign_order word %0d got %0h expected %0h", i, gotQ[i], 8'h30 + 8'(i)); end
      end
      checks++; if (rcA[doneAt] !== 8'd5) begin errors++; $display("[TB] FAIL ign_rd_count_done got %0d expected 5", rcA[doneAt]); end
      checks++; if (rcA[19] !== 8'd5) begin errors++; $display("[TB] FAIL ign_rd_count_end got %0d expected 5", rcA[19]); end
      checks++; if (popCount != 5) begin errors++; $display("[TB] FAIL ign_pops got %0d expected 5", popCount); end
   endtask

   // Random lengths, random FIFO arrival and random sink readiness
   task automatic test_random();
      logic [7:0] pushedQ[$];
      logic [7:0] w;
      logic [7:0] prevData;
      logic       prevStall;
      logic       doneSeen;
      int         len, target, hsCount, lastHs, doneCycle, expDone;
      for (int it = 0; it < 40; it++) begin
         doReset();
         pushedQ.delete();
         len = (it % 8 == 7) ? int'($urandom_range(30, 60)) : int'($urandom_range(0, 12));
         target = len + 2;
         hsCount = 0;
         lastHs = -1;
         doneCycle = -1;
         doneSeen = 1'b0;
         prevStall = 1'b0;
         prevData = '0;
         for (int c = 0; c < 1000; c++) begin
            if (pushedQ.size() < target && $urandom_range(0, 2) != 0) begin
               w = 8'($urandom);
               pushedQ.push_back(w);
               pushWord(w);
            end
            start_i = (c == 0);
            len_i = 8'(len);
            m_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (read_en_o && empty_i) begin errors++; $display("[TB] FAIL rnd_underflow iter %0d cycle %0d got read_en 1 expected 0", it, c); end
            if (prevStall) begin
               checks++; if (m_valid_o !== 1'b1 || m_data_o !== prevData) begin
                  errors++; $display("[TB] FAIL rnd_hold iter %0d cycle %0d got v%0b %0h expected v1 %0h", it, c, m_valid_o, m_data_o, prevData);
               end
            end
            if (c >= 1) begin
               checks++; if (rd_count_o !== 8'(hsCount)) begin errors++; $display("[TB] FAIL rnd_rd_count iter %0d cycle %0d got %0d expected %0d", it, c, rd_count_o, hsCount); end
            end
            if (m_valid_o && m_ready_i) begin
               checks++;
               if (hsCount >= len) begin
                  errors++; $display("[TB] FAIL rnd_extra iter %0d cycle %0d got word %0d expected at most %0d", it, c, hsCount + 1, len);
               end else if (m_data_o !== pushedQ[hsCount]) begin
                  errors++; $display("[TB] FAIL rnd_data iter %0d word %0d got %0h expected %0h", it, hsCount, m_data_o, pushedQ[hsCount]);
               end
               hsCount++;
               lastHs = c;
            end
            if (done_o) begin
               expDone = (len == 0) ? 1 : lastHs + 1;
               checks++; if (doneSeen || c != expDone || hsCount != len) begin
                  errors++; $display("[TB] FAIL rnd_done iter %0d got cycle %0d words %0d expected cycle %0d words %0d", it, c, hsCount, expDone, len);
               end
               doneSeen = 1'b1;
               doneCycle = c;
            end
            prevStall = m_valid_o && !m_ready_i;
            prevData = m_data_o;
            tick();
            if (doneSeen && c >= doneCycle + 2) break;
         end
         checks++; if (!doneSeen) begin errors++; $display("[TB] FAIL rnd_timeout iter %0d got no done expected done within 1000 cycles", it); end
         checks++; if (popCount != len) begin errors++; $display("[TB] FAIL rnd_pops iter %0d got %0d expected %0d", it, popCount, len); end
         #1;
         checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rnd_busy_end iter %0d got %0b expected 0", it, busy_o); end
      end
   endtask

   // Scenario sequence
   initial begin
      rst_i = 1'b1;
      start_i = 1'b0;
      len_i = '0;
      empty_i = 1'b1;
      fifo_dout_i = '0;
      m_ready_i = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic_drain();
      test_back_pressure();
      test_empty_stall();
      test_zero_length();
      test_reset_mid_transfer();
      test_ignored_start();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_read_drainer.md
# fifo_read_drainer

Single-clock read-side controller for the team's FIFOs: on a start command it pops a programmed number of words from a FIFO read port (`read_en` / `dout` / `empty`, one-cycle read latency) and presents them to a downstream valid/ready sink. A 2-entry output buffer absorbs the FIFO read latency, so the block sustains one word per cycle when the sink is always ready and never loses a word under back-pressure. It sits between the FIFO read port and the consumer logic in the read clock domain.

## Interface
- `WIDTH`, 8: data word width.
- `CNT_W`, 8: width of the transfer length and word counter.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle command pulse; ignored while `busy`=1.
- `len`  in  CNT_W  number of words to transfer, sampled when `start` is accepted.
- `empty`  in  1  FIFO empty flag, current-cycle.
- `read_en`  out  1  FIFO pop request, combinational.
- `fifo_dout`  in  WIDTH  FIFO read data, valid one cycle after `read_en`.
- `m_valid`  out  1  output word valid.
- `m_data`  out  WIDTH  output word.
- `m_ready`  in  1  sink accepts the word when `m_valid` & `m_ready`.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `rd_count`  out  CNT_W  words delivered in the current or last transfer.

## Operation
- **States:** IDLE, RUN, FLUSH, DONE.
  - IDLE -> RUN on `start` with `len`!=0. Load `remaining`=`len`, clear `rd_count`.
  - IDLE -> DONE on `start` with `len`=0. No reads are issued.
  - RUN -> FLUSH when the last read is issued (`remaining` reaches 0).
  - FLUSH -> DONE when the buffer is empty, no read is in flight, and the last word has been accepted.
  - DONE -> IDLE unconditionally after one cycle.
- **Read issue:** `read_en` = (state==RUN) & ~`empty` & `remaining`!=0 & (occ + inflight − pop) < 2.
  - occ = buffer entries (0..2); inflight = read issued last cycle (0/1); pop = `m_valid` & `m_ready`.
  - `read_en` is forced to 0 while `rst`=1.
- **Capture:** the cycle after `read_en`, `fifo_dout` is written to the buffer tail.
- **Output:** the buffer head drives `m_data`; `m_valid` = occ!=0.
  - A pop advances the head and increments `rd_count`.
  - Simultaneous capture and pop is legal; occ is unchanged in that case.
- **Counters:**
  - `remaining` decrements by 1 per `read_en`.
  - `rd_count` saturates at 2^CNT_W−1. It cannot overflow because `len` ≤ 2^CNT_W−1.
- `busy` = state ∈ {RUN, FLUSH, DONE}.
- `done` = (state==DONE).
- `empty` mid-transfer stalls issue only; the block waits indefinitely in RUN.
- **Underflow:** none. `read_en` is never asserted with `empty`=1.
- **Overflow:** none. The credit rule bounds occ + inflight ≤ 2.

## Timing
- **Reset values:** `read_en`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0, `rd_count`=0; state IDLE, occ=0, inflight=0, `remaining`=0.
- **Reset mid-transfer:**
  - Everything returns to reset values on the next edge.
  - A read issued in the cycle before reset is discarded; its data is not captured.
  - No `done` pulse is generated.
- **Start latency:** `start` at cycle 0 -> state RUN and first `read_en` at cycle 1 (if `empty`=0) -> data captured at end of cycle 2 -> `m_valid`=1 at cycle 3.
- **Throughput:** with `m_ready` held at 1 and the FIFO non-empty, one word per cycle from cycle 3 onward.
- **Done timing:** last handshake at cycle K -> `done`=1 and state DONE at cycle K+1 -> `busy`=0 at cycle K+2.
- **len=0:** `start` at cycle 0 -> `done` at cycle 1.
- **Stability:** while `m_valid`=1 and `m_ready`=0, `m_data` and `m_valid` hold; at most 2 words are buffered.
- `start` asserted while `busy`=1 has no effect, including in the DONE cycle.

## Test plan
- **Basic drain:** reset, FIFO preloaded with 0x11..0x14, `m_ready`=1, `len`=4, `start` at cycle 0.
  - `read_en` high cycles 1–4.
  - `m_data` 0x11,0x12,0x13,0x14 on cycles 3–6.
  - `done` at cycle 7; `rd_count`=4.
- **Back-pressure:** as above but `m_ready`=0 during cycles 3–8.
  - `read_en` stops after 2 pops.
  - `m_data` holds 0x11 through cycle 8.
  - After `m_ready` rises: no word lost or duplicated, order preserved.
- **Empty stall:** FIFO holds 2 words, `len`=4.
  - After 2 reads, `read_en`=0 and state stays RUN.
  - Writing 2 more words resumes the transfer.
  - `done` follows the 4th handshake.
- **Zero length:** `len`=0, `start`.
  - `read_en` never asserts; `done` at cycle 1.
  - `start` during the DONE cycle is ignored.
- **Reset mid-transfer:** `len`=8, assert `rst` at cycle 4.
  - Next cycle: all outputs at reset values; no `done` pulse.
  - FIFO pops equal the `read_en` pulses issued before reset.
- **Ignored start:** pulse `start` with `len`=3 while `busy`=1 during a `len`=5 transfer -> exactly 5 words delivered; `rd_count`=5.
